// File: rtl/desc_grant_dispatcher_if.sv
// Descriptor grant bus: channel requests/acks plus the engine valid/ready/done handshake.
interface desc_grant_dispatcher_if #(
  parameter int unsigned NUMDESC = 8,
  parameter int unsigned IDXW    = 3
);
  logic [NUMDESC-1:0] req;
  logic [NUMDESC-1:0] ack;
  logic               ack_err;
  logic               eng_valid;
  logic               eng_ready;
  logic [NUMDESC-1:0] eng_grant;
  logic [IDXW-1:0]    eng_idx;
  logic               eng_done;
  logic [NUMDESC-1:0] last_grant;
  logic               busy;

  // Channels and engine side
  modport master (
    output req, eng_ready, eng_done,
    input  ack, ack_err, eng_valid, eng_grant, eng_idx, last_grant, busy
  );

  // Dispatcher side
  modport slave (
    input  req, eng_ready, eng_done,
    output ack, ack_err, eng_valid, eng_grant, eng_idx, last_grant, busy
  );
endinterface

// File: rtl/desc_grant_dispatcher.sv
// Round-robin descriptor dispatcher: picks a requesting channel, offers it to the
// DMA engine, waits for completion or watchdog expiry, then acks the channel.
module desc_grant_dispatcher #(
  parameter int unsigned NUMDESC = 8,
  parameter int unsigned IDXW    = 3,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  desc_grant_dispatcher_if.slave bus
);

  localparam int unsigned     WDW     = 16;
  localparam bit              WD_EN   = (TIMEOUT != 0);
  localparam logic [WDW-1:0]  WD_LAST = WDW'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RELEASE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUMDESC-1:0] r_grant, w_grant_nxt;
  logic [IDXW-1:0]    r_idx, w_idx_nxt;
  logic [NUMDESC-1:0] r_last, w_last_nxt;
  logic [NUMDESC-1:0] r_mask, w_mask_nxt;
  logic [WDW-1:0]     r_wd, w_wd_nxt;
  logic [NUMDESC-1:0] r_ack, w_ack_nxt;
  logic               r_ack_err, w_ack_err_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy, w_busy_nxt;

  logic [NUMDESC-1:0] w_eff;
  logic [NUMDESC-1:0] w_sel_oh;
  logic [IDXW-1:0]    w_sel_idx;
  logic               w_found;

  assign w_eff = bus.req & ~r_mask;

  // Round-robin pick: first eff_req bit strictly above last_grant, wrapping; bit 0 first when last_grant is 0
  always_comb begin
    int unsigned v_start;
    int unsigned v_j;
    w_sel_oh  = '0;
    w_sel_idx = '0;
    w_found   = 1'b0;
    v_start   = NUMDESC - 1;
    v_j       = 0;
    for (int unsigned i = 0; i < NUMDESC; i++) begin
      if (r_last[IDXW'(i)]) v_start = i;
    end
    for (int unsigned k = 1; k <= NUMDESC; k++) begin
      v_j = (v_start + k) % NUMDESC;
      if (!w_found && w_eff[IDXW'(v_j)]) begin
        w_found              = 1'b1;
        w_sel_oh[IDXW'(v_j)] = 1'b1;
        w_sel_idx            = IDXW'(v_j);
      end
    end
  end

  // Next-state and next-output computation
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_idx_nxt     = r_idx;
    w_last_nxt    = r_last;
    w_mask_nxt    = r_mask;
    w_wd_nxt      = r_wd;
    w_ack_nxt     = '0;
    w_ack_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_mask_nxt = '0;
        if (w_found) begin
          w_grant_nxt = w_sel_oh;
          w_idx_nxt   = w_sel_idx;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.eng_ready) begin
          w_wd_nxt    = '0;
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        w_wd_nxt = r_wd + WDW'(1);
        if (bus.eng_done) begin
          w_ack_nxt   = r_grant;
          w_state_nxt = ST_RELEASE;
        end else if (WD_EN && (r_wd == WD_LAST)) begin
          w_ack_nxt     = r_grant;
          w_ack_err_nxt = 1'b1;
          w_state_nxt   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_last_nxt  = r_grant;
        w_mask_nxt  = r_grant;
        w_grant_nxt = '0;
        w_idx_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_valid_nxt = (w_state_nxt == ST_ISSUE);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_last    <= '0;
      r_mask    <= '0;
      r_wd      <= '0;
      r_ack     <= '0;
      r_ack_err <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_idx     <= w_idx_nxt;
      r_last    <= w_last_nxt;
      r_mask    <= w_mask_nxt;
      r_wd      <= w_wd_nxt;
      r_ack     <= w_ack_nxt;
      r_ack_err <= w_ack_err_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign bus.ack        = r_ack;
  assign bus.ack_err    = r_ack_err;
  assign bus.eng_valid  = r_valid;
  assign bus.eng_grant  = r_grant;
  assign bus.eng_idx    = r_idx;
  assign bus.last_grant = r_last;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_desc_grant_dispatcher.sv
// Directed bench for desc_grant_dispatcher: round-robin order, wrap, mask, backpressure,
// watchdog, reset abort and idle behaviour.
module tb_desc_grant_dispatcher;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  desc_grant_dispatcher_if #(.NUMDESC(8), .IDXW(3)) u_if ();
  desc_grant_dispatcher_if #(.NUMDESC(8), .IDXW(3)) u_if0 ();

  desc_grant_dispatcher #(.NUMDESC(8), .IDXW(3), .TIMEOUT(16)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if)
  );

  desc_grant_dispatcher #(.NUMDESC(8), .IDXW(3), .TIMEOUT(0)) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if0)
  );

  int n_total = 0;
  int n_bad   = 0;
  int ack0_cnt = 0;

  // Count acks from the watchdog-disabled instance
  always @(posedge clk) if (u_if0.ack != 8'h00) ack0_cnt <= ack0_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!u_if.eng_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(u_if.eng_valid), 32'd1);
  endtask

  // Offer accepted immediately, done two cycles after handshake, optional req drop after ack
  task automatic run_txn(input logic [7:0] g, input logic [2:0] idx, input bit drop, input string tag);
    wait_valid(tag);
    chk({tag, "_grant"}, 32'(u_if.eng_grant), 32'(g));
    chk({tag, "_idx"}, 32'(u_if.eng_idx), 32'(idx));
    u_if.eng_ready = 1'b1;
    step();
    u_if.eng_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(u_if.eng_valid), 32'd0);
    step();
    u_if.eng_done = 1'b1;
    step();
    u_if.eng_done = 1'b0;
    chk({tag, "_ack"}, 32'(u_if.ack), 32'(g));
    chk({tag, "_ack_err"}, 32'(u_if.ack_err), 32'd0);
    if (drop) u_if.req = u_if.req & ~g;
    step();
    chk({tag, "_ack_clr"}, 32'(u_if.ack), 32'd0);
  endtask

  initial begin
    int cyc;
    int idle_bad;
    rst_n          = 1'b0;
    u_if.req       = 8'h00;
    u_if.eng_ready = 1'b0;
    u_if.eng_done  = 1'b0;
    u_if0.req       = 8'h01;
    u_if0.eng_ready = 1'b1;
    u_if0.eng_done  = 1'b0;
    #12;
    chk("rst_valid", 32'(u_if.eng_valid), 32'd0);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_grant", 32'(u_if.eng_grant), 32'd0);
    chk("rst_last", 32'(u_if.last_grant), 32'd0);
    chk("rst_ack", 32'(u_if.ack), 32'd0);
    step();
    rst_n    = 1'b1;
    u_if.req = 8'h0E;

    // 1: in-order round robin
    step();
    chk("t1_first_valid", 32'(u_if.eng_valid), 32'd1);
    run_txn(8'h02, 3'd1, 1'b1, "t1a");
    chk("t1_gap_valid", 32'(u_if.eng_valid), 32'd0);
    step();
    chk("t1_lat_valid", 32'(u_if.eng_valid), 32'd1);
    run_txn(8'h04, 3'd2, 1'b1, "t1b");
    run_txn(8'h08, 3'd3, 1'b1, "t1c");
    chk("t1_last", 32'(u_if.last_grant), 32'h08);
    step();
    step();
    chk("t1_idle_valid", 32'(u_if.eng_valid), 32'd0);
    chk("t1_idle_busy", 32'(u_if.busy), 32'd0);

    // 2: wrap-around and lone-requester regrant after masked cycle
    u_if.req = 8'h05;
    run_txn(8'h01, 3'd0, 1'b1, "t2a");
    run_txn(8'h04, 3'd2, 1'b1, "t2b");
    u_if.req = 8'h80;
    run_txn(8'h80, 3'd7, 1'b0, "t2c");
    chk("t2_last", 32'(u_if.last_grant), 32'h80);
    chk("t2_masked1", 32'(u_if.eng_valid), 32'd0);
    step();
    chk("t2_masked2", 32'(u_if.eng_valid), 32'd0);
    step();
    chk("t2_regrant", 32'(u_if.eng_valid), 32'd1);
    run_txn(8'h80, 3'd7, 1'b1, "t2d");

    // 3: backpressure with req dropped during ISSUE
    u_if.req = 8'h01;
    step();
    u_if.req = 8'h00;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_hold_valid%0d", i), 32'(u_if.eng_valid), 32'd1);
      chk($sformatf("t3_hold_grant%0d", i), 32'(u_if.eng_grant), 32'h01);
      step();
    end
    u_if.eng_ready = 1'b1;
    step();
    u_if.eng_ready = 1'b0;
    chk("t3_hs_valid", 32'(u_if.eng_valid), 32'd0);
    chk("t3_hs_busy", 32'(u_if.busy), 32'd1);
    step();
    u_if.eng_done = 1'b1;
    step();
    u_if.eng_done = 1'b0;
    chk("t3_ack", 32'(u_if.ack), 32'h01);
    step();

    // 4a: watchdog expiry, ack+err 17 cycles after handshake cycle
    u_if.req = 8'h02;
    step();
    chk("t4a_grant", 32'(u_if.eng_grant), 32'h02);
    u_if.eng_ready = 1'b1;
    step();
    u_if.eng_ready = 1'b0;
    cyc = 1;
    while (u_if.ack == 8'h00 && cyc < 40) begin
      step();
      cyc++;
    end
    chk("t4a_lat", 32'(cyc), 32'd17);
    chk("t4a_ack", 32'(u_if.ack), 32'h02);
    chk("t4a_err", 32'(u_if.ack_err), 32'd1);
    u_if.req = 8'h00;
    step();
    chk("t4a_err_clr", 32'(u_if.ack_err), 32'd0);

    // 4b: done in the expiry cycle wins
    u_if.req = 8'h10;
    step();
    chk("t4b_grant", 32'(u_if.eng_grant), 32'h10);
    u_if.eng_ready = 1'b1;
    step();
    u_if.eng_ready = 1'b0;
    cyc = 1;
    while (u_if.ack == 8'h00 && cyc < 40) begin
      u_if.eng_done = (cyc == 16);
      step();
      cyc++;
    end
    u_if.eng_done = 1'b0;
    chk("t4b_lat", 32'(cyc), 32'd17);
    chk("t4b_ack", 32'(u_if.ack), 32'h10);
    chk("t4b_err", 32'(u_if.ack_err), 32'd0);
    u_if.req = 8'h00;
    step();

    // 4c: watchdog disabled instance stays in WAIT_DONE
    chk("t4c_busy", 32'(u_if0.busy), 32'd1);
    chk("t4c_valid", 32'(u_if0.eng_valid), 32'd0);
    chk("t4c_grant", 32'(u_if0.eng_grant), 32'h01);
    chk("t4c_acks", 32'(ack0_cnt), 32'd0);

    // 5: reset in WAIT_DONE, then last_grant restarts from zero
    u_if.req = 8'h01;
    step();
    chk("t5_grant", 32'(u_if.eng_grant), 32'h01);
    u_if.eng_ready = 1'b1;
    step();
    u_if.eng_ready = 1'b0;
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(u_if.eng_valid), 32'd0);
    chk("t5_rst_grant", 32'(u_if.eng_grant), 32'd0);
    chk("t5_rst_busy", 32'(u_if.busy), 32'd0);
    chk("t5_rst_last", 32'(u_if.last_grant), 32'd0);
    chk("t5_rst0_busy", 32'(u_if0.busy), 32'd0);
    step();
    chk("t5_rst_ack", 32'(u_if.ack), 32'd0);
    u_if.req = 8'h30;
    rst_n    = 1'b1;
    run_txn(8'h10, 3'd4, 1'b1, "t5a");
    run_txn(8'h20, 3'd5, 1'b1, "t5b");

    // 6: idle with stray done, then done ignored in ISSUE
    idle_bad = 0;
    for (int i = 0; i < 50; i++) begin
      u_if.eng_done = (i == 10);
      step();
      if (u_if.eng_valid || u_if.busy || (u_if.ack != 8'h00)) idle_bad++;
    end
    u_if.eng_done = 1'b0;
    chk("t6_idle", 32'(idle_bad), 32'd0);
    u_if.req = 8'h04;
    step();
    chk("t6_issue_valid", 32'(u_if.eng_valid), 32'd1);
    u_if.eng_done = 1'b1;
    step();
    u_if.eng_done = 1'b0;
    chk("t6_done_ign_valid", 32'(u_if.eng_valid), 32'd1);
    chk("t6_done_ign_ack", 32'(u_if.ack), 32'd0);
    step();
    chk("t6_done_ign_ack2", 32'(u_if.ack), 32'd0);
    run_txn(8'h04, 3'd2, 1'b1, "t6b");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/desc_grant_dispatcher.md
Name: desc_grant_dispatcher

Overview:
Consumer side of the descriptor round-robin grant path in the PCIe DMA block. It collects level requests from NUMDESC descriptor channels and picks one with registered round-robin state. It issues the chosen descriptor to the single DMA engine over a valid/ready handshake, waits for completion or timeout, and returns a one-cycle ack to the owning channel. It replaces combinational next-state use with a full sequential issue/complete loop.

Parameters:
NUMDESC, 8, number of descriptor channels (2..32)
IDXW, 3, width of engine index; must equal ceil(log2(NUMDESC))
TIMEOUT, 1023, WAIT_DONE watchdog limit in cycles (1..65535); 0 disables the watchdog

Ports:
clk  in  1  single clock; all state is updated on its rising edge
rst_n  in  1  reset, asynchronous and active-low
req  in  NUMDESC  per-channel request, level; channel drops it the cycle after it sees its ack
ack  out  NUMDESC  one-hot, one-cycle completion pulse to the granted channel
ack_err  out  1  pulses together with ack when the completion was a timeout
eng_valid  out  1  descriptor offer to the engine
eng_ready  in  1  engine accepts the offer
eng_grant  out  NUMDESC  one-hot granted channel; valid while eng_valid or busy
eng_idx  out  IDXW  binary index of eng_grant
eng_done  in  1  engine completion pulse
last_grant  out  NUMDESC  one-hot of the last completed channel (round-robin pointer); 0 after reset
busy  out  1  high in ISSUE, WAIT_DONE and RELEASE

Behaviour:
- Reset (async assert, sync release): state IDLE; ack, ack_err, eng_valid, eng_grant, eng_idx, last_grant, busy, watchdog and mask all cleared. Reset mid-transaction drops eng_valid/eng_grant immediately. The engine treats this as an abort. No ack is generated.
- FSM has four states: IDLE, ISSUE, WAIT_DONE, RELEASE.
- IDLE:
  - eff_req = req & ~mask.
  - If eff_req is 0, stay in IDLE.
  - Otherwise select the first set bit of eff_req at an index strictly above the index of last_grant, wrapping to bit 0. If last_grant is 0, select the lowest set bit.
  - Register eng_grant/eng_idx and go to ISSUE.
  - mask clears after one IDLE cycle.
- ISSUE:
  - eng_valid = 1. eng_grant/eng_idx are held stable until eng_valid & eng_ready.
  - Dropping req does not retract the offer.
  - eng_done is ignored in this state.
  - On handshake, go to WAIT_DONE and clear the watchdog.
- WAIT_DONE:
  - eng_valid = 0; the watchdog increments every cycle.
  - eng_done = 1: go to RELEASE, timeout flag = 0.
  - Else, if TIMEOUT != 0 and this is the TIMEOUT-th WAIT_DONE cycle: go to RELEASE, timeout flag = 1.
  - If eng_done and expiry happen in the same cycle, done wins (no error).
- RELEASE:
  - ack = eng_grant for exactly one cycle; ack_err = timeout flag.
  - last_grant <= eng_grant; mask <= eng_grant.
  - Go to IDLE.
- Latency:
  - req seen in IDLE at cycle N gives eng_valid at N+1.
  - eng_done at cycle M gives ack at M+1 and the earliest next eng_valid at M+3.
- Fairness: a channel holding req is granted again only if no other eff_req bit is set. Once the single-cycle mask has expired, a lone requester may be regranted back-to-back.
- eng_idx is always the binary encoding of eng_grant; eng_grant is never multi-hot.

Test Plan:
1. Reset, req=0x0E held, each channel drops req the cycle after its ack, eng_ready=1, eng_done 2 cycles after handshake -> grants 0x02, 0x04, 0x08 in order (idx 1, 2, 3); ack pulses match; last_grant ends at 0x08; then IDLE with eng_valid=0.
2. Wrap-around: last_grant=0x08, req=0x05 -> eng_grant=0x01, idx=0; next grant 0x04. With last_grant=0x80 and req=0x80 alone -> regrant 0x80 after the one masked IDLE cycle.
3. Backpressure: eng_ready low for 5 cycles in ISSUE while req drops -> eng_valid and eng_grant stable for all 5 cycles; handshake on cycle 6; ack still delivered later.
4. Timeout with TIMEOUT=16: handshake at cycle H, no eng_done -> ack and ack_err at H+17; with eng_done at H+16 instead -> ack at H+17, ack_err=0. With TIMEOUT=0 and no done -> WAIT_DONE indefinitely.
5. Reset in WAIT_DONE -> outputs 0 the same cycle with no ack; after release, req=0x30 -> grant 0x10, since last_grant reset to 0.
6. req=0 in IDLE for 50 cycles -> no eng_valid, busy=0; an eng_done pulse in IDLE or ISSUE -> no ack.
